// File: rtl/fp32_sub_seq.sv
// Multi-cycle IEEE-754 binary32 subtractor (result = a - b), truncating, no rounding.
// Special operands resolve on accept; ordinary ones walk ALIGN -> ADD -> NORM -> DONE.
module fp32_sub_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result
);

   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_a, r_b, r_result, w_bNeg, w_specRes;
   logic [7:0]       r_exp, w_ea, w_eb;
   logic [23:0]      r_ma, r_mb, r_sum, w_ma, w_mb;
   logic [24:0]      w_sum;
   logic             r_sign, w_addSign, w_special, w_normDone;
   logic             w_aNan, w_bNan, w_aInf, w_bInf, w_aZero, w_bZero;

   assign w_bNeg  = {~b[WIDTH-1], b[WIDTH-2:0]};
   assign w_aNan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
   assign w_bNan  = (w_bNeg[30:23] == 8'hFF) && (w_bNeg[22:0] != 23'd0);
   assign w_aInf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
   assign w_bInf  = (w_bNeg[30:23] == 8'hFF) && (w_bNeg[22:0] == 23'd0);
   assign w_aZero = (a[30:0] == 31'd0);
   assign w_bZero = (w_bNeg[30:0] == 31'd0);

   // Special-case resolution in priority order; evaluated on the raw inputs at accept.
   always_comb begin
      w_special = 1'b1;
      w_specRes = '0;
      if (w_aNan || w_bNan)
         w_specRes = 32'h7FC0_0000;
      else if (w_aInf && w_bInf)
         w_specRes = (a[31] == w_bNeg[31]) ? {a[31], 8'hFF, 23'd0} : 32'h7FC0_0000;
      else if (w_aInf)
         w_specRes = a;
      else if (w_bInf)
         w_specRes = w_bNeg;
      else if (w_aZero && w_bZero)
         w_specRes = {a[31] & w_bNeg[31], 31'd0};
      else if (w_aZero)
         w_specRes = w_bNeg;
      else if (w_bZero)
         w_specRes = a;
      else
         w_special = 1'b0;
   end

   assign w_ea = r_a[30:23];
   assign w_eb = r_b[30:23];
   assign w_ma = {|w_ea, r_a[22:0]};
   assign w_mb = {|w_eb, r_b[22:0]};

   always_comb begin
      w_sum     = '0;
      w_addSign = r_a[31];
      if (r_a[31] == r_b[31]) begin
         w_sum = {1'b0, r_ma} + {1'b0, r_mb};
      end else if (r_ma >= r_mb) begin
         w_sum = {1'b0, r_ma - r_mb};
      end else begin
         w_sum     = {1'b0, r_mb - r_ma};
         w_addSign = r_b[31];
      end
   end

   // Exponents of 0 or 1 cannot absorb another left shift, so those flush to zero.
   assign w_normDone = (r_sum == 24'd0) || r_sum[23] || (r_exp <= 8'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (in_valid) w_next = w_special ? DONE : ALIGN;
         ALIGN:   w_next = ADD;
         ADD:     w_next = NORM;
         NORM:    if (w_normDone) w_next = DONE;
         DONE:    if (out_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == IDLE);
      out_valid = (r_state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_ma     <= '0;
         r_mb     <= '0;
         r_sum    <= '0;
         r_exp    <= '0;
         r_sign   <= 1'b0;
         r_result <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a <= a;
                  r_b <= w_bNeg;
                  if (w_special) r_result <= w_specRes;
               end
            end
            ALIGN: begin
               if (w_ea >= w_eb) begin
                  r_ma  <= w_ma;
                  r_mb  <= w_mb >> (w_ea - w_eb);
                  r_exp <= w_ea;
               end else begin
                  r_ma  <= w_ma >> (w_eb - w_ea);
                  r_mb  <= w_mb;
                  r_exp <= w_eb;
               end
            end
            ADD: begin
               r_sign <= w_addSign;
               if (w_sum[24]) begin
                  // Overflow parks a bare hidden bit at exponent FF so NORM emits infinity.
                  if (r_exp == 8'hFE) r_sum <= 24'h80_0000;
                  else                r_sum <= w_sum[24:1];
                  r_exp <= r_exp + 8'd1;
               end else begin
                  r_sum <= w_sum[23:0];
               end
            end
            NORM: begin
               if (r_sum == 24'd0) begin
                  r_result <= '0;
               end else if (r_sum[23]) begin
                  r_result <= {r_sign, r_exp, r_sum[22:0]};
               end else begin
                  r_sum <= r_sum << 1;
                  r_exp <= r_exp - 8'd1;
                  if (r_exp <= 8'd1) r_result <= {r_sign, 31'd0};
               end
            end
            default: ;
         endcase
      end
   end

   assign result = r_result;

endmodule

// File: tb/tb_fp32_sub_seq.sv
// Self-checking bench for fp32_sub_seq: an arithmetic reference model scored every cycle,
// plus directed vectors whose results and latencies were worked out by hand.
module tb_fp32_sub_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] result;

   int testsRun = 0;
   int testsFailed = 0;

   fp32_sub_seq #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %08h, expected %08h", name, actual, expected);
      end
   endtask

   // Reference model: a + (-b) with exact integer mantissas, truncation and the same
   // special-value priority; lat counts rising edges from accept (inclusive) to out_valid.
   function automatic void fpModel(input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] r, output int lat);
      logic [31:0] yb;
      logic        sa, sb, s;
      int          ea, eb, fa, fb, e, k;
      longint      ma, mb, sum;
      yb = {~y[31], y[30:0]};
      sa = x[31];
      sb = yb[31];
      ea = int'(x[30:23]);
      eb = int'(yb[30:23]);
      fa = int'(x[22:0]);
      fb = int'(yb[22:0]);
      r = '0;
      lat = 1;
      if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0))  r = 32'h7FC0_0000;
      else if (ea == 255 && eb == 255) r = (sa == sb) ? {sa, 8'hFF, 23'd0} : 32'h7FC0_0000;
      else if (ea == 255)                                     r = x;
      else if (eb == 255)                                     r = yb;
      else if (ea == 0 && fa == 0 && eb == 0 && fb == 0)     r = {sa & sb, 31'd0};
      else if (ea == 0 && fa == 0)                            r = yb;
      else if (eb == 0 && fb == 0)                            r = x;
      else begin
         ma = longint'(fa) + ((ea != 0) ? 64'sd8388608 : 64'sd0);
         mb = longint'(fb) + ((eb != 0) ? 64'sd8388608 : 64'sd0);
         if (ea >= eb) begin
            e  = ea;
            mb = (ea - eb >= 24) ? 0 : (mb >> (ea - eb));
         end else begin
            e  = eb;
            ma = (eb - ea >= 24) ? 0 : (ma >> (eb - ea));
         end
         if (sa == sb)      begin sum = ma + mb; s = sa; end
         else if (ma >= mb) begin sum = ma - mb; s = sa; end
         else               begin sum = mb - ma; s = sb; end
         if (sum >= 64'sd16777216) begin
            sum = sum / 2;
            e   = e + 1;
         end
         if (e >= 255) begin
            r   = {s, 8'hFF, 23'd0};
            lat = 4;
         end else begin
            k   = 0;
            lat = -1;
            while (lat < 0) begin
               if (sum == 0) begin
                  r = '0;
                  lat = 4 + k;
               end else if (sum >= 64'sd8388608) begin
                  r = {s, e[7:0], sum[22:0]};
                  lat = 4 + k;
               end else begin
                  sum = sum * 2;
                  e   = e - 1;
                  k++;
                  if (e <= 0) begin
                     r = {s, 31'd0};
                     lat = 3 + k;
                  end
               end
            end
         end
      end
   endfunction

   // Every-cycle scoreboard, sampled on the falling edge.
   logic [31:0] expRes;
   logic [31:0] lastResult = '0;
   int          expLat = 0;
   int          since = 0;
   bit          pending = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         checkOutput("reset-out_valid", 32'(out_valid), 32'd0);
         checkOutput("reset-result", result, 32'd0);
         pending    = 1'b0;
         lastResult = '0;
      end else if (pending) begin
         since++;
         checkOutput("busy-in_ready", 32'(in_ready), 32'd0);
         if (since < expLat) begin
            checkOutput("early-out_valid", 32'(out_valid), 32'd0);
            checkOutput("early-result-held", result, lastResult);
         end else begin
            checkOutput("done-out_valid", 32'(out_valid), 32'd1);
            checkOutput("done-result", result, expRes);
            if (out_valid && out_ready) begin
               pending    = 1'b0;
               lastResult = expRes;
            end
         end
      end else begin
         checkOutput("idle-in_ready", 32'(in_ready), 32'd1);
         checkOutput("idle-out_valid", 32'(out_valid), 32'd0);
         checkOutput("idle-result-held", result, lastResult);
         if (in_valid && in_ready) begin
            fpModel(a, b, expRes, expLat);
            since   = 0;
            pending = 1'b1;
         end
      end
   end

   task automatic applyStimulus(input logic [31:0] opA, input logic [31:0] opB, input int hold,
                                input bit pulse, output logic [31:0] got, output int lat);
      int guard;
      got = 32'hDEAD_BEEF;
      lat = -1;
      out_ready = (hold == 0);
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!in_ready) begin
         checkOutput("accept-timeout", 32'(in_ready), 32'd1);
         out_ready = 1'b1;
         return;
      end
      a = opA;
      b = opB;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
      lat = 1;
      while (!out_valid && lat < 100) begin
         in_valid = pulse && (lat == 2);
         @(posedge clk); #1;
         lat++;
      end
      in_valid = 1'b0;
      if (!out_valid) begin
         checkOutput("out_valid-timeout", 32'(out_valid), 32'd1);
         out_ready = 1'b1;
         lat = -1;
         return;
      end
      got = result;
      repeat (hold) begin
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("release-out_valid", 32'(out_valid), 32'd0);
      checkOutput("release-in_ready", 32'(in_ready), 32'd1);
   endtask

   typedef struct {
      logic [31:0] opA;
      logic [31:0] opB;
      logic [31:0] want;
      int          lat;
      int          hold;
      bit          pulse;
   } row_t;

   row_t rows[16];

   initial begin
      logic [31:0] got, modelRes;
      int          lat, modelLat;

      rows = '{
         '{32'h3F80_0000, 32'h3F00_0000, 32'h3F00_0000,  5, 0, 1'b0},
         '{32'h4040_0000, 32'h3F80_0000, 32'h4000_0000,  4, 0, 1'b0},
         '{32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000,  4, 0, 1'b0},
         '{32'hC000_0000, 32'h4000_0000, 32'hC080_0000,  4, 0, 1'b0},
         '{32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000,  4, 0, 1'b0},
         '{32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000,  1, 0, 1'b0},
         '{32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000,  1, 0, 1'b0},
         '{32'h0000_0000, 32'h3F80_0000, 32'hBF80_0000,  1, 0, 1'b0},
         '{32'h8000_0000, 32'h0000_0000, 32'h8000_0000,  1, 0, 1'b0},
         '{32'h4000_0000, 32'hBF80_0000, 32'h4040_0000,  4, 0, 1'b0},
         '{32'h3F80_0000, 32'h3F7F_FFFF, 32'h3400_0000, 27, 0, 1'b0},
         '{32'h4120_0000, 32'h3F80_0000, 32'h4110_0000,  4, 0, 1'b0},
         '{32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000,  1, 0, 1'b0},
         '{32'h3F80_0000, 32'hFF80_0000, 32'h7F80_0000,  1, 0, 1'b0},
         '{32'h4B00_0000, 32'h3F80_0000, 32'h4AFF_FFFE,  5, 0, 1'b0},
         '{32'h4040_0000, 32'h3F80_0000, 32'h4000_0000,  4, 3, 1'b1}
      };

      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      checkOutput("por-out_valid", 32'(out_valid), 32'd0);
      checkOutput("por-result", result, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      checkOutput("por-in_ready", 32'(in_ready), 32'd1);

      foreach (rows[i]) begin
         fpModel(rows[i].opA, rows[i].opB, modelRes, modelLat);
         checkOutput($sformatf("model-result-%0d", i), modelRes, rows[i].want);
         checkOutput($sformatf("model-latency-%0d", i), 32'(modelLat), 32'(rows[i].lat));
         applyStimulus(rows[i].opA, rows[i].opB, rows[i].hold, rows[i].pulse, got, lat);
         checkOutput($sformatf("dut-result-%0d", i), got, rows[i].want);
         checkOutput($sformatf("dut-latency-%0d", i), 32'(lat), 32'(rows[i].lat));
      end

      // Reset while the long normalisation of 1.0 - (1.0 - ulp) is in progress.
      a = 32'h3F80_0000;
      b = 32'h3F7F_FFFF;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midop-reset-out_valid", 32'(out_valid), 32'd0);
      checkOutput("midop-reset-result", result, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      checkOutput("midop-release-in_ready", 32'(in_ready), 32'd1);
      repeat (30) @(posedge clk);
      #1;
      checkOutput("midop-no-stale-out_valid", 32'(out_valid), 32'd0);
      applyStimulus(32'h3F80_0000, 32'h3F00_0000, 0, 1'b0, got, lat);
      checkOutput("post-reset-result", got, 32'h3F00_0000);
      checkOutput("post-reset-latency", 32'(lat), 32'd5);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/fp32_sub_seq.md
FP32_SUB_SEQ -- requirements
Module: fp32_sub_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; only 32 (IEEE-754 binary32) is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid  input  1  operand pair a, b is valid.
REQ-005 SHALL have port in_ready  output  1  block can accept an operand pair.
REQ-006 SHALL have port a  input  WIDTH  minuend, FP32.
REQ-007 SHALL have port b  input  WIDTH  subtrahend, FP32.
REQ-008 SHALL have port out_valid  output  1  result is valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port result  output  WIDTH  a - b, FP32.

Function
REQ-011 SHALL compute result = a + b', where b' = {~b[31], b[30:0]}; all rules below apply to the pair (a, b').
REQ-012 SHALL capture a and b' on a clock edge where in_valid && in_ready; in_ready SHALL equal (state == IDLE).
REQ-013 SHALL implement the FSM IDLE -> ALIGN -> ADD -> NORM -> DONE -> IDLE; special operands go IDLE -> DONE directly.
REQ-014 Specials, in priority order: either NaN -> 7FC00000; both inf, same sign -> {sign,FF,0}; both inf, opposite sign -> 7FC00000; one inf -> that inf; both zero -> {a_sign & b'_sign,00,0}; a zero -> b'; b' zero -> a.
REQ-015 ALIGN SHALL form 24-bit mantissas with hidden bit 1 (0 when exp == 00, exponent used as-is), then right-shift the smaller-exponent mantissa by the exponent difference, truncating shifted-out bits; ties in exponent go to a.
REQ-016 ADD SHALL, for equal signs, form the 25-bit sum with sign = a sign; for unequal signs, subtract the smaller magnitude from the larger, taking the larger one's sign, with a on equality.
REQ-017 ADD SHALL, if sum bit 24 is set, shift the sum right 1 (truncate) and increment the exponent; an exponent reaching FF SHALL yield {sign,FF,0}.
REQ-018 NORM SHALL, each cycle: if sum == 0, result 00000000 -> DONE; else if sum[23] == 1, result {sign,exp,sum[22:0]} -> DONE; else shift left 1 and decrement exp, and if exp reaches 00, result {sign,00,0} -> DONE (flush).
REQ-019 SHALL perform no rounding; truncation only, bit-exact to REQ-015..018.
REQ-020 Latency SHALL be: special case, out_valid high after 1 edge following accept; normal case, after 4 + k edges, where k = number of NORM left shifts.
REQ-021 SHALL hold out_valid and result stable in DONE until out_valid && out_ready, then go to IDLE; in_ready SHALL rise the following cycle, with no same-cycle accept.
REQ-022 SHALL ignore in_valid while not IDLE; a and b may change freely after capture.
REQ-023 result SHALL be registered and SHALL keep its last value after handshake until the next DONE.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, out_valid 0, result 00000000, and in_ready 1 after release.
REQ-025 Reset mid-operation (any state) SHALL discard the in-flight operation; no out_valid for it after release.
REQ-026 Handshakes SHALL be possible from the first rising edge after rst_n deasserts.

Verification
REQ-027 3F800000 - 3F000000 (1.0-0.5), out_ready=1 -> result 3F000000, k=1, out_valid 5 edges after accept.
REQ-028 40400000 - 3F800000 (3.0-1.0) -> 40000000, k=0, out_valid 4 edges after accept; 3F800000 - 3F800000 -> 00000000.
REQ-029 C0000000 - 40000000 -> C0800000 (carry path); 7F7FFFFF - FF7FFFFF -> 7F800000 (overflow).
REQ-030 7F800000 - 7F800000 -> 7FC00000; 7FC00001 - 3F800000 -> 7FC00000; 00000000 - 3F800000 -> BF800000; 80000000 - 00000000 -> 80000000; each with out_valid 1 edge after accept.
REQ-031 out_ready held low 3 cycles in DONE -> out_valid and result stable, in_ready 0; in_valid pulsed during busy -> ignored.
REQ-032 rst_n pulsed low during NORM of 3F800000 - 3F7FFFFF -> out_valid 0 and state IDLE immediately, no stale result after release; next operation correct.
